// File: rtl/maxpool2x2_relu_stream.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a row-major pixel stream.
// Build option: define MAXPOOL_RELU_EN to apply ReLU before pooling; undefined pools raw floats.
module maxpool2x2_relu_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  // Handshake: valid-only stream, no ready; a pixel is consumed on every clk with valid_in=1,
  // and valid_out/frame_done are single-cycle strobes the downstream must take immediately.

  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int DEPTH = WIDTH / 2;

  // Order key over IEEE-754 bit patterns; with ReLU every operand is non-negative so raw bits suffice.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
`ifdef MAXPOOL_RELU_EN
    return x;
`else
    return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] activate(input logic [DATA_WIDTH-1:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[DATA_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Ties keep the earlier operand a.
  function automatic logic [DATA_WIDTH-1:0] pick_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    return (order_key(b) > order_key(a)) ? b : a;
  endfunction

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] linebuf [DEPTH];
  logic [DATA_WIDTH-1:0] pix;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] vmax;
  logic                  last_col;
  logic                  last_row;

  always_comb begin
    pix      = activate(data_in);
    hmax     = pick_max(hold, pix);
    vmax     = pick_max(linebuf[col[CW-1:1]], hmax);
    last_col = (col == CW'(WIDTH - 1));
    last_row = (row == RW'(HEIGHT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col[0]) hold <= pix;
        if (col[0] && row[0]) begin
          data_out   <= vmax;
          valid_out  <= 1'b1;
          frame_done <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Half-row buffer of horizontal maxima from the even row; no reset needed, written before read.
  always_ff @(posedge clk) begin
    if (valid_in && col[0] && !row[0]) linebuf[col[CW-1:1]] <= hmax;
  end

endmodule

// File: tb/tb_maxpool2x2_relu_stream.sv
// Bench: a 4x2 instance for hand-computed cases and a 112x112 instance for random frames.
module tb_maxpool2x2_relu_stream;

  localparam int DW = 32;
  localparam int W  = 112;
  localparam int H  = 112;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int NWIN = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_din = '0, b_din = '0;
  logic          s_vin = 1'b0, b_vin = 1'b0;
  logic          s_br = 1'b0, s_last = 1'b0, b_br = 1'b0, b_last = 1'b0;
  logic [DW-1:0] s_dout, b_dout;
  logic          s_vout, s_fd, b_vout, b_fd;
  logic          s_due, s_fd_due, b_due, b_fd_due;

  logic [DW-1:0] s_exp_q[$];
  logic [DW-1:0] b_exp_q[$];
  logic [DW-1:0] frame [W*H];

  int total = 0, bad = 0;
  int s_out_cnt = 0, s_fd_cnt = 0, b_out_cnt = 0, b_fd_cnt = 0;

  maxpool2x2_relu_stream #(.DATA_WIDTH(DW), .WIDTH(SW), .HEIGHT(SH)) dut_small (
    .clk(clk), .rst(rst), .data_in(s_din), .valid_in(s_vin),
    .data_out(s_dout), .valid_out(s_vout), .frame_done(s_fd)
  );

  maxpool2x2_relu_stream #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .data_in(b_din), .valid_in(b_vin),
    .data_out(b_dout), .valid_out(b_vout), .frame_done(b_fd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference ordering, written from the float semantics rather than the datapath.
  function automatic logic [DW-1:0] ref_act(input logic [DW-1:0] x);
`ifdef MAXPOOL_RELU_EN
    if (x[31]) return 32'h0;
`endif
    return x;
  endfunction

  function automatic logic [DW-1:0] ref_key(input logic [DW-1:0] x);
`ifdef MAXPOOL_RELU_EN
    return x;
`else
    if (x[31]) return ~x;
    return {1'b1, x[30:0]};
`endif
  endfunction

  function automatic logic [DW-1:0] ref_pool(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] v [4];
    logic [DW-1:0] best;
    v[0] = ref_act(a); v[1] = ref_act(b); v[2] = ref_act(c); v[3] = ref_act(d);
    best = v[0];
    for (int k = 1; k < 4; k++) if (ref_key(v[k]) > ref_key(best)) best = v[k];
    return best;
  endfunction

  function automatic logic [DW-1:0] rand_float();
    logic [31:0] r;
    if ($urandom_range(0, 31) == 0) return 32'h8000_0000;
    r = $urandom();
    return {r[31], 8'($urandom_range(120, 135)), r[22:0]};
  endfunction

  // Expected strobe timing: one cycle after a bottom-right pixel is accepted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_due <= 1'b0; s_fd_due <= 1'b0; b_due <= 1'b0; b_fd_due <= 1'b0;
    end else begin
      s_due    <= s_vin && s_br;
      s_fd_due <= s_vin && s_br && s_last;
      b_due    <= b_vin && b_br;
      b_fd_due <= b_vin && b_br && b_last;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (s_vout || s_due) begin
      check("s_strobe", 64'(s_vout), 64'(s_due));
      check("s_frame_done", 64'(s_fd), 64'(s_fd_due));
      if (s_vout) begin
        s_out_cnt++;
        if (s_exp_q.size() == 0) check("s_unexpected_out", 64'(s_dout), 64'hdead);
        else begin
          e = s_exp_q.pop_front();
          check("s_data", 64'(s_dout), 64'(e));
        end
      end
    end else if (s_fd) check("s_stray_frame_done", 64'(s_fd), 64'd0);
    if (s_fd) s_fd_cnt++;

    if (b_vout || b_due) begin
      check("b_strobe", 64'(b_vout), 64'(b_due));
      check("b_frame_done", 64'(b_fd), 64'(b_fd_due));
      if (b_vout) begin
        b_out_cnt++;
        if (b_exp_q.size() == 0) check("b_unexpected_out", 64'(b_dout), 64'hdead);
        else begin
          e = b_exp_q.pop_front();
          check("b_data", 64'(b_dout), 64'(e));
        end
      end
    end else if (b_fd) check("b_stray_frame_done", 64'(b_fd), 64'd0);
    if (b_fd) b_fd_cnt++;
  end

  task automatic drive_small(input logic [DW-1:0] px [SW*SH]);
    for (int i = 0; i < SW*SH; i++) begin
      @(negedge clk);
      s_vin  = 1'b1;
      s_din  = px[i];
      s_br   = ((i / SW) % 2 == 1) && ((i % SW) % 2 == 1);
      s_last = (i == SW*SH - 1);
    end
  endtask

  task automatic fill_frame();
    for (int i = 0; i < W*H; i++) frame[i] = rand_float();
  endtask

  task automatic push_frame_exp(input int n_win);
    for (int k = 0; k < n_win; k++) begin
      int r0, c0;
      r0 = 2 * (k / (W / 2));
      c0 = 2 * (k % (W / 2));
      b_exp_q.push_back(ref_pool(frame[r0*W + c0], frame[r0*W + c0 + 1],
                                 frame[(r0+1)*W + c0], frame[(r0+1)*W + c0 + 1]));
    end
  endtask

  task automatic drive_big(input int n_pix, input bit gaps);
    for (int i = 0; i < n_pix; i++) begin
      int r, c, g;
      r = i / W;
      c = i % W;
      g = (gaps && $urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
      repeat (g) begin
        @(negedge clk);
        b_vin = 1'b0;
      end
      @(negedge clk);
      b_vin  = 1'b1;
      b_din  = frame[i];
      b_br   = (r % 2 == 1) && (c % 2 == 1);
      b_last = (r == H - 1) && (c == W - 1);
    end
  endtask

  task automatic drain_big(input string tag);
    int n;
    n = 0;
    while (b_exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, 64'(b_exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] px [SW*SH];

    #1;
    check("rst_s_dout", 64'(s_dout), 64'd0);
    check("rst_s_vout", 64'(s_vout), 64'd0);
    check("rst_s_fd",   64'(s_fd),   64'd0);
    check("rst_b_dout", 64'(b_dout), 64'd0);
    check("rst_b_vout", 64'(b_vout), 64'd0);
    check("rst_b_fd",   64'(b_fd),   64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 4x2 worked example followed immediately by negative/tie windows.
    px = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
           32'hBF800000, 32'h3F000000, 32'h3F000000, 32'h40400000};
    s_exp_q.push_back(32'h40000000);
    s_exp_q.push_back(32'h40400000);
    drive_small(px);
    px = '{32'hBF800000, 32'hC0000000, 32'h3F800000, 32'h3F800000,
           32'hBF000000, 32'hC0400000, 32'h3F800000, 32'h3F800000};
`ifdef MAXPOOL_RELU_EN
    s_exp_q.push_back(32'h00000000);
`else
    s_exp_q.push_back(32'hBF000000);
`endif
    s_exp_q.push_back(32'h3F800000);
    drive_small(px);
    @(negedge clk);
    s_vin = 1'b0;
    repeat (3) @(negedge clk);
    check("s_out_count", 64'(s_out_cnt), 64'd4);
    check("s_fd_count", 64'(s_fd_cnt), 64'd2);
    check("s_q_empty", 64'(s_exp_q.size()), 64'd0);

    // Full frame with random valid_in gaps.
    b_out_cnt = 0; b_fd_cnt = 0;
    fill_frame();
    push_frame_exp(NWIN);
    drive_big(W*H, 1'b1);
    @(negedge clk);
    b_vin = 1'b0;
    drain_big("b_q_empty_gaps");
    check("b_out_count_gaps", 64'(b_out_cnt), 64'(NWIN));
    check("b_fd_count_gaps", 64'(b_fd_cnt), 64'd1);

    // Partial frame: row 0 plus 50 pixels of row 1, then asynchronous reset.
    b_out_cnt = 0; b_fd_cnt = 0;
    fill_frame();
    push_frame_exp(25);
    drive_big(W + 50, 1'b0);
    @(negedge clk);
    b_vin = 1'b0;
    @(negedge clk);
    check("b_partial_outs", 64'(b_out_cnt), 64'd25);
    #2 rst = 1'b1;
    #1;
    check("midrst_dout", 64'(b_dout), 64'd0);
    check("midrst_vout", 64'(b_vout), 64'd0);
    check("midrst_fd",   64'(b_fd),   64'd0);
    check("midrst_q", 64'(b_exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Two back-to-back frames after reset, no idle cycles.
    b_out_cnt = 0; b_fd_cnt = 0;
    fill_frame();
    push_frame_exp(NWIN);
    drive_big(W*H, 1'b0);
    fill_frame();
    push_frame_exp(NWIN);
    drive_big(W*H, 1'b0);
    @(negedge clk);
    b_vin = 1'b0;
    drain_big("b_q_empty_b2b");
    check("b_out_count_b2b", 64'(b_out_cnt), 64'(2 * NWIN));
    check("b_fd_count_b2b", 64'(b_fd_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
